uart_tx_buffered: RTL and testbench

//  Buffered 8N1 UART transmitter for the user project. Accepts bytes on a val/rdy

---
 rtl/uart_tx_buffered_pkg.sv | 20 ++
 rtl/uart_tx_buffered_sync_fifo.sv | 70 +++++++
 rtl/uart_tx_buffered.sv | 128 ++++++++++++
 tb/tb_uart_tx_buffered.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffered_pkg
//  Description : Shared constants for the buffered 8N1 UART transmitter:
//                FSM state encodings and the frame data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_buffered_pkg;

    // Number of payload bits per frame (8N1)
    localparam int unsigned c_UART_DATA_BITS = 8;

    // Transmitter FSM state encodings
    localparam logic [1:0] c_UART_IDLE  = 2'd0;
    localparam logic [1:0] c_UART_START = 2'd1;
    localparam logic [1:0] c_UART_DATA  = 2'd2;
    localparam logic [1:0] c_UART_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_buffered_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with val/rdy on both sides and an
//                occupancy count. Pointers wrap naturally (DEPTH is a power
//                of two); count saturates at DEPTH, which is "full".
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_val,
    output logic                     enq_rdy,
    input  logic [WIDTH-1:0]         enq_msg,
    output logic                     deq_val,
    input  logic                     deq_rdy,
    output logic [WIDTH-1:0]         deq_msg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              c_PW   = $clog2(DEPTH);
    localparam logic [c_PW:0]   c_FULL = (c_PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW:0]    r_count;
    logic             w_enq;
    logic             w_deq;

    assign enq_rdy = (r_count != c_FULL);
    assign deq_val = (r_count != '0);
    assign deq_msg = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign w_enq   = enq_val && enq_rdy;
    assign w_deq   = deq_val && deq_rdy;

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= enq_msg;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push/pop keeps count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (c_PW + 1)'(1);
                2'b01:   r_count <= r_count - (c_PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffered
//  Description : Buffered 8N1 UART transmitter. Bytes are accepted on a
//                val/rdy port into a FIFO and serialised LSB-first on tx.
//                A frame is 10*CLKS_PER_BIT cycles followed by one IDLE cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [7:0]                    in_msg,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int                c_TW         = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0]   c_TIMER_LAST = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        c_LAST_BIT   = 3'(c_UART_DATA_BITS - 1);

    logic [1:0]                        r_state;
    logic [c_TW-1:0]                   r_timer;
    logic [2:0]                        r_bit_idx;
    logic [c_UART_DATA_BITS-1:0]       r_shift;
    logic                              r_tx;

    logic                              w_deq_val;
    logic                              w_deq_rdy;
    logic [7:0]                        w_deq_msg;
    logic [$clog2(FIFO_DEPTH):0]       w_count;
    logic                              w_bit_done;
    logic [c_UART_DATA_BITS-1:0]       w_shift_next;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq_val (in_val),
        .enq_rdy (in_rdy),
        .enq_msg (in_msg),
        .deq_val (w_deq_val),
        .deq_rdy (w_deq_rdy),
        .deq_msg (w_deq_msg),
        .count   (w_count)
    );

    // The FSM only pops while idle, so the pop and the start-bit edge coincide
    assign w_deq_rdy    = (r_state == c_UART_IDLE);
    assign w_bit_done   = (r_timer == c_TIMER_LAST);
    assign w_shift_next = {1'b0, r_shift[c_UART_DATA_BITS-1:1]};

    assign tx    = r_tx;
    assign count = w_count;
    assign busy  = (r_state != c_UART_IDLE) || (w_count != '0);

    // Frame sequencer: tx is registered, so each state drives the next bit level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_UART_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                c_UART_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_deq_val) begin
                        r_shift <= w_deq_msg;
                        r_timer <= '0;
                        r_state <= c_UART_START;
                        r_tx    <= 1'b0;
                    end
                end
                c_UART_START: begin
                    if (w_bit_done) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= c_UART_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                c_UART_DATA: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_state <= c_UART_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                        end
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                c_UART_STOP: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_state <= c_UART_IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                default: begin
                    r_state <= c_UART_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_buffered
//  Description : Self-checking bench for uart_tx_buffered (CLKS_PER_BIT=4,
//                FIFO_DEPTH=4). A queue-based frame model predicts every
//                output each cycle; an independent line decoder recovers
//                bytes and start times from tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       in_val = 1'b0;
    logic [7:0] in_msg = 8'h00;
    logic       in_rdy;
    logic       tx;
    logic       busy;
    logic [2:0] count;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_val (in_val),
        .in_rdy (in_rdy),
        .in_msg (in_msg),
        .tx     (tx),
        .busy   (busy),
        .count  (count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    bit         m_in_frame = 0;
    int         m_pos      = 0;
    logic [7:0] m_cur      = 8'h00;
    bit         m_accept   = 0;

    // Frame bit k of the current frame: 0 = start, 1..8 = data LSB first, 9 = stop
    function automatic logic m_tx();
        int k;
        if (!m_in_frame) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge();
        int occ;
        m_accept = 0;
        if (reset) begin
            m_q.delete();
            m_in_frame = 0;
            m_pos      = 0;
        end else begin
            occ      = m_q.size();
            m_accept = in_val && (occ < DEPTH);
            if (m_in_frame) begin
                m_pos++;
                if (m_pos == 10 * CPB) m_in_frame = 0;
            end else if (occ > 0) begin
                m_cur      = m_q.pop_front();
                m_in_frame = 1;
                m_pos      = 0;
            end
            if (m_accept) m_q.push_back(in_msg);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance model at the edge, then compare all outputs
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("tx",     {31'd0, tx},     {31'd0, m_tx()});
        check("busy",   {31'd0, busy},   {31'd0, (m_in_frame || m_q.size() != 0)});
        check("count",  {29'd0, count},  32'(m_q.size()));
        check("in_rdy", {31'd0, in_rdy}, {31'd0, (m_q.size() < DEPTH)});
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit done;
        done   = 0;
        in_val = 1'b1;
        in_msg = b;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (m_accept) done = 1;
        end
        if (!done) check("push_timeout", 32'd0, 32'd1);
        in_val = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            step();
            if (!m_in_frame && m_q.size() == 0) done = 1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- independent line decoder ----------------
    logic [7:0] mon_q[$];
    int         mon_starts[$];
    bit         mon_finished = 0;

    initial begin
        int         mstate;
        int         mcnt;
        int         mcyc;
        logic [7:0] mbyte;
        mstate = 0;
        mcnt   = 0;
        mcyc   = 0;
        mbyte  = 8'h00;
        forever begin
            @(negedge clk);
            mcyc++;
            if (reset) begin
                mstate = 0;
            end else if (mstate == 0) begin
                if (tx == 1'b0) begin
                    mstate = 1;
                    mcnt   = 0;
                    mon_starts.push_back(mcyc);
                end
            end else begin
                mcnt++;
                for (int k = 1; k <= 8; k++)
                    if (mcnt == k * CPB + CPB / 2) mbyte[k-1] = tx;
                if (mcnt == 9 * CPB + CPB / 2) begin
                    if (tx == 1'b1) begin
                        mon_q.push_back(mbyte);
                        if (mbyte == 8'h0A) mon_finished = 1;
                    end
                    mstate = 0;
                end
            end
        end
    end

    task automatic mon_clear();
        mon_q.delete();
        mon_starts.delete();
        mon_finished = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] fr;
        logic [7:0] t3 [5];
        bit         got;

        // Reset held 3 cycles: outputs at their reset values after every edge
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tx",     {31'd0, tx},     32'd1);
            check("rst_busy",   {31'd0, busy},   32'd0);
            check("rst_count",  {29'd0, count},  32'd0);
            check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        end
        reset = 1'b0;
        step();
        step();

        // Single byte A5: fixed waveform, busy drops 41 cycles after the push
        fr = {1'b1, 8'hA5, 1'b0};
        push_byte(8'hA5);
        for (int k = 1; k <= 41; k++) begin
            step();
            if (k <= 40) check("a5_tx", {31'd0, tx}, {31'd0, fr[(k-1)/CPB]});
            if (k == 40) check("a5_busy_hi", {31'd0, busy}, 32'd1);
            if (k == 41) begin
                check("a5_busy_lo", {31'd0, busy}, 32'd0);
                check("a5_tx_idle", {31'd0, tx},   32'd1);
            end
        end

        // Five back-to-back pushes with the FSM idle
        mon_clear();
        t3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            push_byte(t3[i]);
            if (i == 1) check("pushpop_count", {29'd0, count}, 32'd1);
        end
        check("full_count",  {29'd0, count},  32'd4);
        check("full_in_rdy", {31'd0, in_rdy}, 32'd0);
        wait_idle();
        step();
        step();
        check("t3_nbytes", 32'(mon_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("t3_byte", {24'd0, mon_q[i]}, {24'd0, t3[i]});
        for (int i = 1; i < 5; i++)
            check("t3_spacing", 32'(mon_starts[i] - mon_starts[i-1]), 32'd41);

        // Held byte against a full FIFO
        for (int i = 0; i < 5; i++) push_byte(8'h80 + 8'(i));
        in_val = 1'b1;
        in_msg = 8'hE7;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_count",  {29'd0, count},  32'd4);
            check("hold_in_rdy", {31'd0, in_rdy}, 32'd0);
        end
        push_byte(8'hE7);
        check("held_accept_count", {29'd0, count}, 32'd4);
        wait_idle();

        // Reset in the middle of data bit 3 of 3C
        push_byte(8'h3C);
        for (int i = 0; i < 18; i++) step();
        check("mid_bit3_tx", {31'd0, tx}, {31'd0, 1'b1});
        reset = 1'b1;
        step();
        check("abort_tx",    {31'd0, tx},    32'd1);
        check("abort_count", {29'd0, count}, 32'd0);
        check("abort_busy",  {31'd0, busy},  32'd0);
        reset = 1'b0;
        mon_clear();
        step();
        push_byte(8'h5A);
        wait_idle();
        step();
        check("post_rst_nbytes", 32'(mon_q.size()), 32'd1);
        check("post_rst_byte",   {24'd0, mon_q[0]}, 32'h5A);

        // "OK\n" through the line decoder
        mon_clear();
        push_byte(8'h4F);
        push_byte(8'h4B);
        push_byte(8'h0A);
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            step();
            if (mon_finished) got = 1;
        end
        check("ok_finished", {31'd0, got}, 32'd1);
        check("ok_nbytes", 32'(mon_q.size()), 32'd3);
        check("ok_b0", {24'd0, mon_q[0]}, 32'h4F);
        check("ok_b1", {24'd0, mon_q[1]}, 32'h4B);
        check("ok_b2", {24'd0, mon_q[2]}, 32'h0A);
        wait_idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            in_val = ($urandom_range(0, 3) == 0);
            in_msg = 8'($urandom);
            reset  = ($urandom_range(0, 199) == 0);
            step();
        end
        reset  = 1'b0;
        in_val = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
